cache_refill_ctrl: RTL and testbench

Blocking miss handler that sits directly upstream of the 64-bit direct-mapped `basic_cache`. It accepts one aligned read request at a time and issues the lookup. On a hit it returns the cached doubleword. On a miss it fetches the doubleword over the memory request/response interface, writes it into the cache, and returns it. It also keeps hit/miss performance counters.

---
 rtl/basic_cache_params.sv | 5 +
 rtl/cache_ctrl_pkg.sv | 15 +
 rtl/cache_refill_ctrl.sv | 121 ++++++++++++
 tb/tb_cache_refill_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/basic_cache_params.sv
// Geometry of the 64-bit direct-mapped basic_cache this controller fronts.
package basic_cache_params;
  localparam int unsigned aligned_addr_size = 40;
  localparam int unsigned data_size         = 64;
endpackage

// File: rtl/cache_ctrl_pkg.sv
// Shared types and widths for the blocking cache refill controller.
package cache_ctrl_pkg;
  localparam int unsigned CC_ADDR_W = basic_cache_params::aligned_addr_size;
  localparam int unsigned CC_DATA_W = basic_cache_params::data_size;
  localparam int unsigned PERF_W    = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_MEM_REQ,
    ST_MEM_WAIT,
    ST_FILL,
    ST_RESP
  } refill_state_t;
endpackage

// File: rtl/cache_refill_ctrl.sv
// Blocking miss handler: hit returns 2 cycles after accept, miss refills via memory then responds.
// One request in flight; req_ready low until the response handshake, response/mem request held under stall.
module cache_refill_ctrl
  import cache_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = CC_ADDR_W,
  parameter int unsigned DATA_W = CC_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_error,
  output logic [ADDR_W-1:0] cache_raddr,
  input  logic [DATA_W-1:0] cache_rdata,
  input  logic              cache_lookup_valid,
  output logic              cache_we,
  output logic [ADDR_W-1:0] cache_waddr,
  output logic [DATA_W-1:0] cache_wdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_data,
  input  logic              mem_resp_error,
  output logic [31:0]       perf_hits,
  output logic [31:0]       perf_misses
);

  refill_state_t     r_state;
  refill_state_t     w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic              r_err;
  logic [PERF_W-1:0] r_hits;
  logic [PERF_W-1:0] r_misses;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_addr   <= '0;
      r_data   <= '0;
      r_err    <= 1'b0;
      r_hits   <= '0;
      r_misses <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        ST_IDLE: begin
          if (req_valid) r_addr <= req_addr;
        end
        ST_LOOKUP: begin
          if (cache_lookup_valid) begin
            r_data <= cache_rdata;
            r_err  <= 1'b0;
            r_hits <= r_hits + PERF_W'(1);
          end else begin
            r_misses <= r_misses + PERF_W'(1);
          end
        end
        ST_MEM_WAIT: begin
          // Faulting data is zeroed so nothing stale can leak out on resp_data.
          if (mem_resp_valid) begin
            r_data <= mem_resp_error ? '0 : mem_resp_data;
            r_err  <= mem_resp_error;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    req_ready     = 1'b0;
    resp_valid    = 1'b0;
    mem_req_valid = 1'b0;
    cache_we      = 1'b0;
    cache_raddr   = r_addr;
    case (r_state)
      ST_IDLE: begin
        // Lookup is launched from the raw request so the cache answers in LOOKUP.
        req_ready   = rst;
        cache_raddr = req_addr;
        if (req_valid) w_state_nxt = ST_LOOKUP;
      end
      ST_LOOKUP: begin
        w_state_nxt = cache_lookup_valid ? ST_RESP : ST_MEM_REQ;
      end
      ST_MEM_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) w_state_nxt = ST_MEM_WAIT;
      end
      ST_MEM_WAIT: begin
        if (mem_resp_valid) w_state_nxt = mem_resp_error ? ST_RESP : ST_FILL;
      end
      ST_FILL: begin
        cache_we    = 1'b1;
        w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign resp_data    = r_data;
  assign resp_error   = r_err;
  assign mem_req_addr = r_addr;
  assign cache_waddr  = r_addr;
  assign cache_wdata  = r_data;
  assign perf_hits    = r_hits;
  assign perf_misses  = r_misses;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Bench for cache_refill_ctrl: cache and memory models plus a transaction-level reference.
module tb_cache_refill_ctrl;
  localparam int AW = 40;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [AW-1:0] req_addr = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic [DW-1:0] resp_data;
  logic          resp_error;
  logic [AW-1:0] cache_raddr;
  logic [DW-1:0] cache_rdata;
  logic          cache_lookup_valid;
  logic          cache_we;
  logic [AW-1:0] cache_waddr;
  logic [DW-1:0] cache_wdata;
  logic          mem_req_valid;
  logic          mem_req_ready = 1'b0;
  logic [AW-1:0] mem_req_addr;
  logic          mem_resp_valid = 1'b0;
  logic [DW-1:0] mem_resp_data = '0;
  logic          mem_resp_error = 1'b0;
  logic [31:0]   perf_hits;
  logic [31:0]   perf_misses;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cache_refill_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_error(resp_error),
    .cache_raddr(cache_raddr), .cache_rdata(cache_rdata), .cache_lookup_valid(cache_lookup_valid),
    .cache_we(cache_we), .cache_waddr(cache_waddr), .cache_wdata(cache_wdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data), .mem_resp_error(mem_resp_error),
    .perf_hits(perf_hits), .perf_misses(perf_misses)
  );

  // Direct-mapped cache model, 256 lines indexed by addr[7:0], one-cycle read.
  bit [DW-1:0] cm_data [256];
  bit [AW-1:0] cm_addr [256];
  bit          cm_vld  [256];
  always @(posedge clk) begin
    cache_rdata        <= cm_data[cache_raddr[7:0]];
    cache_lookup_valid <= cm_vld[cache_raddr[7:0]] && (cm_addr[cache_raddr[7:0]] == cache_raddr);
    if (cache_we) begin
      cm_data[cache_waddr[7:0]] <= cache_wdata;
      cm_addr[cache_waddr[7:0]] <= cache_waddr;
      cm_vld[cache_waddr[7:0]]  <= 1'b1;
    end
  end

  // Reference: which address owns each line, its data, and expected counters.
  bit [AW-1:0] ref_addr [int];
  bit [DW-1:0] ref_data [int];
  int unsigned ref_hits = 0;
  int unsigned ref_misses = 0;

  typedef struct {
    bit          hit;
    bit [DW-1:0] data;
    bit          err;
    int          mreq_hs;
    int          we_cnt;
    int          resp_cycle;
  } exp_t;

  typedef struct {
    int          acc_wait;
    int          mreq_hs;
    int          mreq_first;
    logic [AW-1:0] mreq_addr;
    int          we_cnt;
    int          we_cycle;
    logic [AW-1:0] we_addr;
    logic [DW-1:0] we_data;
    bit          got_resp;
    int          resp_cycle;
    logic [DW-1:0] resp_data;
    logic        resp_err;
    bit          unstable;
    bit          rdy_in_resp;
    bit          timeout;
  } obs_t;

  task automatic ref_apply(input bit [AW-1:0] a, input bit [DW-1:0] d, input bit e,
                           input int stall, input int lat, output exp_t x);
    int idx;
    int mresp;
    idx   = int'(a[7:0]);
    mresp = 2 + stall + 1 + lat;
    x.hit = ref_addr.exists(idx) && (ref_addr[idx] == a);
    if (x.hit) begin
      x.data = ref_data[idx]; x.err = 1'b0; x.mreq_hs = 0; x.we_cnt = 0; x.resp_cycle = 2;
      ref_hits++;
    end else begin
      ref_misses++;
      x.mreq_hs = 1;
      x.err     = e;
      x.data    = e ? '0 : d;
      x.we_cnt  = e ? 0 : 1;
      x.resp_cycle = mresp + (e ? 1 : 2);
      if (!e) begin
        ref_addr[idx] = a;
        ref_data[idx] = d;
      end
    end
  endtask

  // Drives one request end to end, playing memory and consumer; cycle 0 is the accept cycle.
  task automatic run_txn(input bit [AW-1:0] a, input bit [DW-1:0] d, input bit e,
                         input int stall, input int lat, input int bp,
                         input bit glitch, input bit noise, output obs_t o);
    int stall_left, lat_left, bp_left;
    bit pend, done;
    o = '{default: 0};
    stall_left = stall; bp_left = bp; lat_left = 0; pend = 0; done = 0;
    @(negedge clk);
    resp_ready = 0; mem_req_ready = 0; mem_resp_valid = 0;
    req_valid = 1; req_addr = a;
    while (!req_ready && o.acc_wait < 50) begin
      @(negedge clk);
      o.acc_wait++;
    end
    if (!req_ready) begin
      o.timeout = 1;
      req_valid = 0;
      return;
    end
    for (int c = 1; c < 300 && !done; c++) begin
      @(negedge clk);
      req_valid = 0; req_addr = AW'({$urandom, $urandom});
      mem_req_ready = 0; mem_resp_valid = 0; mem_resp_error = 0;
      mem_resp_data = DW'({$urandom, $urandom}); resp_ready = 0;
      if (mem_req_valid) begin
        if (o.mreq_first == 0) begin
          o.mreq_first = c; o.mreq_addr = mem_req_addr;
        end else if (mem_req_addr !== o.mreq_addr) o.unstable = 1;
        if (stall_left == 0) begin
          mem_req_ready = 1; o.mreq_hs++; pend = 1; lat_left = lat;
          if (glitch) begin
            mem_resp_valid = 1; mem_resp_data = ~d; mem_resp_error = ~e;
          end
        end else stall_left--;
      end else if (pend) begin
        if (lat_left == 0) begin
          mem_resp_valid = 1; mem_resp_data = d; mem_resp_error = e; pend = 0;
        end else lat_left--;
      end else if (noise && $urandom_range(1) == 1) begin
        mem_resp_valid = 1; mem_resp_data = ~d; mem_resp_error = 1'($urandom_range(1));
      end
      if (cache_we) begin
        o.we_cnt++; o.we_cycle = c; o.we_addr = cache_waddr; o.we_data = cache_wdata;
      end
      if (resp_valid) begin
        if (!o.got_resp) begin
          o.got_resp = 1; o.resp_cycle = c; o.resp_data = resp_data; o.resp_err = resp_error;
        end else if (resp_data !== o.resp_data || resp_error !== o.resp_err) o.unstable = 1;
        if (req_ready) o.rdy_in_resp = 1;
        if (bp_left == 0) begin
          resp_ready = 1; done = 1;
        end else bp_left--;
      end
    end
    if (!done) o.timeout = 1;
  endtask

  task automatic test_reset;
    #2;
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
    checks++; if (mem_req_valid !== 1'b0) begin failures++; $display("FAIL reset_mem_req_valid: got %b want 0", mem_req_valid); end
    checks++; if (cache_we !== 1'b0) begin failures++; $display("FAIL reset_cache_we: got %b want 0", cache_we); end
    checks++; if (perf_hits !== 32'd0 || perf_misses !== 32'd0) begin failures++; $display("FAIL reset_perf: got %0d/%0d want 0/0", perf_hits, perf_misses); end
    repeat (2) @(negedge clk);
    rst = 1;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_cold_miss;
    exp_t x; obs_t o;
    ref_apply(40'h100, 64'hDEADBEEF_CAFEF00D, 0, 3, 2, x);
    run_txn(40'h100, 64'hDEADBEEF_CAFEF00D, 0, 3, 2, 0, 0, 0, o);
    checks++; if (o.timeout) begin failures++; $display("FAIL cold_timeout: got timeout want completion"); end
    checks++; if (o.mreq_hs != 1 || o.mreq_addr !== 40'h100) begin failures++; $display("FAIL cold_mem_req: got %0d reqs addr %h want 1 addr 100", o.mreq_hs, o.mreq_addr); end
    checks++; if (o.mreq_first != 2) begin failures++; $display("FAIL cold_mem_req_cycle: got %0d want 2", o.mreq_first); end
    checks++; if (o.we_cnt != 1 || o.we_addr !== 40'h100 || o.we_data !== 64'hDEADBEEF_CAFEF00D) begin failures++; $display("FAIL cold_fill: got %0d writes %h/%h want 1 100/deadbeefcafef00d", o.we_cnt, o.we_addr, o.we_data); end
    checks++; if (o.resp_data !== 64'hDEADBEEF_CAFEF00D || o.resp_err !== 1'b0) begin failures++; $display("FAIL cold_resp: got %h err %b want deadbeefcafef00d err 0", o.resp_data, o.resp_err); end
    checks++; if (o.resp_cycle != 10) begin failures++; $display("FAIL cold_latency: got %0d want 10", o.resp_cycle); end
    checks++; if (perf_misses !== 32'd1 || perf_hits !== 32'd0) begin failures++; $display("FAIL cold_perf: got %0d/%0d want 0/1", perf_hits, perf_misses); end
  endtask

  task automatic test_hit_after_fill;
    exp_t x; obs_t o;
    ref_apply(40'h100, 64'h1, 0, 0, 0, x);
    run_txn(40'h100, 64'h1, 0, 0, 0, 0, 0, 1, o);
    checks++; if (o.mreq_hs != 0 || o.mreq_first != 0) begin failures++; $display("FAIL hit_no_mem: got %0d mem reqs want 0", o.mreq_hs); end
    checks++; if (o.resp_cycle != 2) begin failures++; $display("FAIL hit_latency: got %0d want 2", o.resp_cycle); end
    checks++; if (o.resp_data !== 64'hDEADBEEF_CAFEF00D) begin failures++; $display("FAIL hit_data: got %h want deadbeefcafef00d", o.resp_data); end
    checks++; if (o.we_cnt != 0) begin failures++; $display("FAIL hit_no_fill: got %0d writes want 0", o.we_cnt); end
    checks++; if (perf_hits !== 32'd1) begin failures++; $display("FAIL hit_perf: got %0d want 1", perf_hits); end
  endtask

  task automatic test_conflict_alias;
    exp_t x; obs_t o;
    ref_apply(40'h200, 64'h2222_0000_AAAA_5555, 0, 0, 1, x);
    run_txn(40'h200, 64'h2222_0000_AAAA_5555, 0, 0, 1, 0, 0, 0, o);
    checks++; if (o.mreq_hs != 1 || o.resp_data !== 64'h2222_0000_AAAA_5555) begin failures++; $display("FAIL alias_first: got %0d reqs data %h want 1 2222_0000_aaaa_5555", o.mreq_hs, o.resp_data); end
    ref_apply(40'h100, 64'h1111_0000_BBBB_6666, 0, 1, 0, x);
    run_txn(40'h100, 64'h1111_0000_BBBB_6666, 0, 1, 0, 0, 0, 0, o);
    checks++; if (o.mreq_hs != 1 || o.resp_data !== 64'h1111_0000_BBBB_6666) begin failures++; $display("FAIL alias_refetch: got %0d reqs data %h want 1 1111_0000_bbbb_6666", o.mreq_hs, o.resp_data); end
    checks++; if (perf_misses !== 32'd3) begin failures++; $display("FAIL alias_perf: got %0d want 3", perf_misses); end
  endtask

  task automatic test_mem_error;
    exp_t x; obs_t o;
    ref_apply(40'h40, 64'h0BAD_0BAD_0BAD_0BAD, 1, 0, 2, x);
    run_txn(40'h40, 64'h0BAD_0BAD_0BAD_0BAD, 1, 0, 2, 0, 0, 0, o);
    checks++; if (o.resp_err !== 1'b1 || o.resp_data !== '0) begin failures++; $display("FAIL err_resp: got %h err %b want 0 err 1", o.resp_data, o.resp_err); end
    checks++; if (o.we_cnt != 0) begin failures++; $display("FAIL err_no_fill: got %0d writes want 0", o.we_cnt); end
    checks++; if (o.resp_cycle != x.resp_cycle) begin failures++; $display("FAIL err_latency: got %0d want %0d", o.resp_cycle, x.resp_cycle); end
    ref_apply(40'h40, 64'h4040_4040_0000_0001, 0, 0, 0, x);
    run_txn(40'h40, 64'h4040_4040_0000_0001, 0, 0, 0, 0, 0, 0, o);
    checks++; if (o.mreq_hs != 1 || o.resp_err !== 1'b0 || o.resp_data !== 64'h4040_4040_0000_0001) begin failures++; $display("FAIL err_retry: got %0d reqs data %h err %b want 1 4040404000000001 0", o.mreq_hs, o.resp_data, o.resp_err); end
  endtask

  task automatic test_backpressure;
    exp_t x; obs_t o;
    ref_apply(40'h40, 64'h0, 0, 0, 0, x);
    run_txn(40'h40, 64'h0, 0, 0, 0, 5, 0, 0, o);
    checks++; if (o.unstable) begin failures++; $display("FAIL bp_stable: got unstable response want stable"); end
    checks++; if (o.rdy_in_resp) begin failures++; $display("FAIL bp_req_ready: got req_ready=1 during response want 0"); end
    checks++; if (o.resp_data !== 64'h4040_4040_0000_0001) begin failures++; $display("FAIL bp_data: got %h want 4040404000000001", o.resp_data); end
    ref_apply(40'h141, 64'h9, 0, 2, 0, x);
    run_txn(40'h141, 64'h9, 0, 2, 0, 0, 0, 0, o);
    checks++; if (o.acc_wait != 0) begin failures++; $display("FAIL bp_next_accept: got %0d extra cycles want 0", o.acc_wait); end
  endtask

  task automatic test_random;
    exp_t x; obs_t o;
    bit [AW-1:0] a; bit [DW-1:0] d; bit e;
    int stall, lat, bp;
    bit [7:0] idx_tab [4];
    idx_tab[0] = 8'h00; idx_tab[1] = 8'h40; idx_tab[2] = 8'h41; idx_tab[3] = 8'h7F;
    for (int i = 0; i < 40; i++) begin
      a     = (AW'($urandom_range(3)) << 8) | AW'(idx_tab[$urandom_range(3)]);
      d     = {$urandom, $urandom};
      e     = ($urandom_range(7) == 0);
      stall = $urandom_range(3); lat = $urandom_range(3); bp = $urandom_range(2);
      ref_apply(a, d, e, stall, lat, x);
      run_txn(a, d, e, stall, lat, bp, 1'($urandom_range(1)), 1'($urandom_range(1)), o);
      checks++; if (o.timeout || o.acc_wait != 0) begin failures++; $display("FAIL rand_accept[%0d]: got timeout=%b wait=%0d want 0/0", i, o.timeout, o.acc_wait); end
      checks++; if (o.resp_data !== x.data || o.resp_err !== x.err) begin failures++; $display("FAIL rand_resp[%0d]: got %h err %b want %h err %b", i, o.resp_data, o.resp_err, x.data, x.err); end
      checks++; if (o.mreq_hs != x.mreq_hs) begin failures++; $display("FAIL rand_mem_reqs[%0d]: got %0d want %0d", i, o.mreq_hs, x.mreq_hs); end
      checks++; if (o.we_cnt != x.we_cnt) begin failures++; $display("FAIL rand_fills[%0d]: got %0d want %0d", i, o.we_cnt, x.we_cnt); end
      checks++; if (o.resp_cycle != x.resp_cycle) begin failures++; $display("FAIL rand_latency[%0d]: got %0d want %0d", i, o.resp_cycle, x.resp_cycle); end
      checks++; if (o.unstable) begin failures++; $display("FAIL rand_stable[%0d]: got unstable want stable", i); end
      checks++; if (perf_hits !== ref_hits || perf_misses !== ref_misses) begin failures++; $display("FAIL rand_perf[%0d]: got %0d/%0d want %0d/%0d", i, perf_hits, perf_misses, ref_hits, ref_misses); end
      if (!x.hit) begin
        checks++; if (o.mreq_addr !== a || o.mreq_first != 2) begin failures++; $display("FAIL rand_mem_addr[%0d]: got %h at %0d want %h at 2", i, o.mreq_addr, o.mreq_first, a); end
      end
      if (x.we_cnt == 1) begin
        checks++; if (o.we_addr !== a || o.we_data !== d || o.we_cycle != x.resp_cycle - 1) begin failures++; $display("FAIL rand_fill[%0d]: got %h/%h at %0d want %h/%h at %0d", i, o.we_addr, o.we_data, o.we_cycle, a, d, x.resp_cycle - 1); end
      end
    end
  endtask

  task automatic test_async_reset;
    int n;
    bit bad;
    @(negedge clk);
    resp_ready = 0; req_valid = 1; req_addr = 40'h5599;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    req_valid = 0;
    n = 0;
    while (!mem_req_valid && n < 20) begin @(negedge clk); n++; end
    checks++; if (mem_req_valid !== 1'b1) begin failures++; $display("FAIL arst_reach_mem_req: got %b want 1", mem_req_valid); end
    mem_req_ready = 1;
    @(negedge clk);
    mem_req_ready = 0;
    #2 rst = 0;
    #1;
    checks++; if (mem_req_valid !== 1'b0 || resp_valid !== 1'b0 || cache_we !== 1'b0 || req_ready !== 1'b0) begin failures++; $display("FAIL arst_outputs: got mreq=%b resp=%b we=%b rdy=%b want 0000", mem_req_valid, resp_valid, cache_we, req_ready); end
    checks++; if (perf_hits !== 32'd0 || perf_misses !== 32'd0) begin failures++; $display("FAIL arst_perf: got %0d/%0d want 0/0", perf_hits, perf_misses); end
    ref_hits = 0; ref_misses = 0;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    mem_resp_valid = 1; mem_resp_data = 64'h1234_5678; mem_resp_error = 0;
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      mem_resp_valid = 0;
      if (cache_we || resp_valid) bad = 1;
    end
    checks++; if (bad) begin failures++; $display("FAIL arst_spurious_resp: got cache_we/resp_valid after reset want none"); end
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL arst_idle: got req_ready=%b want 1", req_ready); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_cold_miss();
    test_hit_after_fill();
    test_conflict_alias();
    test_mem_error();
    test_backpressure();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
